mem_dma: RTL and testbench

Single-channel DMA initiator that drives the byte-addressed, 16-bit-word data memory port (MemRead/MemWrite, 8-bit address, big-endian word at addr/addr+1). It copies a block of words from a source to a destination address, or fills a block with a constant. It sits between the control sequencer and data memory, holding the memory port while busy.

---
 rtl/mem_dma.sv | 127 ++++++++++++
 tb/tb_mem_dma.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/mem_dma.sv
// mem_dma: single-channel DMA that copies or fills a block of 16-bit words over the byte-addressed data memory port
module mem_dma #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              fill,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] fill_data,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [LEN_W-1:0]  words_done,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  typedef enum logic [2:0] {IDLE, RD, CAP, WR, DONE} state_t;
  state_t            state;
  logic [ADDR_W-1:0] src_p, dst_p, src_nxt, dst_nxt;
  logic [LEN_W-1:0]  len_r, wd_nxt;
  logic              fill_r, last;
  logic [DATA_W-1:0] fdata_r;
  assign src_nxt = src_p + ADDR_W'(2);
  assign dst_nxt = dst_p + ADDR_W'(2);
  assign wd_nxt  = words_done + LEN_W'(1);
  assign last    = (wd_nxt == len_r) || abort;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      src_p      <= '0;
      dst_p      <= '0;
      len_r      <= '0;
      fill_r     <= 1'b0;
      fdata_r    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      words_done <= '0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: if (start) begin
          if ((!fill && src_addr[0]) || dst_addr[0]) err <= 1'b1;
          else if (len == '0) begin
            words_done <= '0;
            done       <= 1'b1;
            state      <= DONE;
          end else begin
            src_p      <= src_addr;
            dst_p      <= dst_addr;
            len_r      <= len;
            fill_r     <= fill;
            fdata_r    <= fill_data;
            words_done <= '0;
            busy       <= 1'b1;
            if (fill) begin
              state     <= WR;
              mem_write <= 1'b1;
              mem_addr  <= dst_addr;
              mem_wdata <= fill_data;
            end else begin
              state    <= RD;
              mem_read <= 1'b1;
              mem_addr <= src_addr;
            end
          end
        end
        RD: begin
          mem_read <= 1'b0;
          state    <= abort ? DONE : CAP;
          if (abort) begin
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
        // mem_wdata doubles as the capture buffer for the word in flight
        CAP: begin
          mem_wdata <= mem_rdata;
          if (abort) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            mem_write <= 1'b1;
            mem_addr  <= dst_p;
            state     <= WR;
          end
        end
        WR: begin
          words_done <= wd_nxt;
          src_p      <= src_nxt;
          dst_p      <= dst_nxt;
          if (last) begin
            mem_write <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end else if (fill_r) begin
            mem_addr  <= dst_nxt;
            mem_wdata <= fdata_r;
          end else begin
            mem_write <= 1'b0;
            mem_read  <= 1'b1;
            mem_addr  <= src_nxt;
            state     <= RD;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_dma.sv
// tb_mem_dma: table-driven check of copy/fill/err/len0 transfers plus abort and async-reset sequences
module tb_mem_dma;
  logic        clk = 0, reset = 0, start = 0, fill = 0, abort = 0;
  logic [7:0]  src_addr = 0, dst_addr = 0, mem_addr;
  logic [6:0]  len = 0, words_done;
  logic [15:0] fill_data = 0, mem_wdata, mem_rdata = 0;
  logic        busy, done, err, mem_read, mem_write;
  logic [7:0]  mem [256];
  logic [7:0]  pre [10] = '{8'h2B, 8'hCD, 8'h00, 8'h00, 8'h12, 8'h34, 8'hDE, 8'hAD, 8'hEF, 8'hEF};
  int n_cmp = 0, n_bad = 0, cyc = 0, st_cyc = 0, ev_cyc = -1, both = 0;
  int rd_cnt, wr_cnt, busy_cnt, done_cnt, err_cnt;
  int wa [$];

  typedef struct {
    logic fill; logic [7:0] src, dst; logic [6:0] len; logic [15:0] fd;
    int e_err, e_done, e_words, e_lat, e_busy, e_rd, e_wr;
  } vec_t;
  vec_t tbl [8];

  mem_dma dut (.clk(clk), .reset(reset), .start(start), .fill(fill), .src_addr(src_addr),
    .dst_addr(dst_addr), .len(len), .fill_data(fill_data), .abort(abort), .busy(busy),
    .done(done), .err(err), .words_done(words_done), .mem_read(mem_read),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!reset) for (int i = 0; i < 256; i++) mem[i] <= (i < 10) ? pre[i] : 8'(i * 7 + 3);
    else begin
      if (mem_read) mem_rdata <= {mem[mem_addr], mem[mem_addr + 8'd1]};
      if (mem_write) begin
        mem[mem_addr]        <= mem_wdata[15:8];
        mem[mem_addr + 8'd1] <= mem_wdata[7:0];
      end
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (start) st_cyc = cyc;
    if (mem_read) rd_cnt++;
    if (mem_write) begin wr_cnt++; wa.push_back(int'(mem_addr)); end
    if (busy) busy_cnt++;
    if (done) done_cnt++;
    if (err) err_cnt++;
    if ((done || err) && ev_cyc < 0) ev_cyc = cyc;
    if (mem_read && mem_write) both++;
  end

  function automatic logic [15:0] wd(input logic [7:0] a);
    return {mem[a], mem[a + 8'd1]};
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic clr();
    rd_cnt = 0; wr_cnt = 0; busy_cnt = 0; done_cnt = 0; err_cnt = 0; ev_cyc = -1;
    wa.delete();
  endtask

  task automatic wait_ev();
    for (int i = 0; i < 300 && ev_cyc < 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
  endtask

  task automatic kick(input logic f, input logic [7:0] s, input logic [7:0] d,
                      input logic [6:0] l, input logic [15:0] fd);
    clr();
    @(posedge clk); #1;
    fill = f; src_addr = s; dst_addr = d; len = l; fill_data = fd; start = 1;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic run(input vec_t v, input string nm);
    logic [15:0] ew [16];
    for (int i = 0; i < 16; i++) ew[i] = v.fill ? v.fd : wd(8'(v.src + 8'(2 * i)));
    kick(v.fill, v.src, v.dst, v.len, v.fd);
    wait_ev();
    chk({nm, ".err"}, err_cnt, v.e_err);
    chk({nm, ".done"}, done_cnt, v.e_done);
    chk({nm, ".words"}, int'(words_done), v.e_words);
    chk({nm, ".lat"}, ev_cyc - st_cyc, v.e_lat);
    chk({nm, ".busy"}, busy_cnt, v.e_busy);
    chk({nm, ".rd"}, rd_cnt, v.e_rd);
    chk({nm, ".wr"}, wr_cnt, v.e_wr);
    for (int i = 0; i < v.e_wr; i++) begin
      chk($sformatf("%s.waddr%0d", nm, i), i < wa.size() ? wa[i] : -1, int'(8'(v.dst + 8'(2 * i))));
      chk($sformatf("%s.wdata%0d", nm, i), int'(wd(8'(v.dst + 8'(2 * i)))), int'(ew[i]));
    end
  endtask

  initial begin
    int n;
    tbl[0] = '{1'b0, 8'h00, 8'h20, 7'd5, 16'h0000, 0, 1, 5, 16, 15, 5, 5};
    tbl[1] = '{1'b1, 8'h00, 8'h40, 7'd3, 16'hA5A5, 0, 1, 3, 4, 3, 0, 3};
    tbl[2] = '{1'b0, 8'h03, 8'h30, 7'd2, 16'h0000, 1, 0, 3, 1, 0, 0, 0};
    tbl[3] = '{1'b1, 8'h00, 8'h41, 7'd2, 16'h7777, 1, 0, 3, 1, 0, 0, 0};
    tbl[4] = '{1'b0, 8'h10, 8'h50, 7'd0, 16'h0000, 0, 1, 0, 1, 0, 0, 0};
    tbl[5] = '{1'b1, 8'h00, 8'hFC, 7'd4, 16'h1111, 0, 1, 4, 5, 4, 0, 4};
    tbl[6] = '{1'b0, 8'h80, 8'h90, 7'd2, 16'h0000, 0, 1, 2, 7, 6, 2, 2};
    tbl[7] = '{1'b1, 8'h03, 8'h70, 7'd1, 16'hBEEF, 0, 1, 1, 2, 1, 0, 1};
    repeat (3) @(negedge clk);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.err", err, 0);
    chk("rst.words", int'(words_done), 0);
    chk("rst.mem_read", mem_read, 0);
    chk("rst.mem_write", mem_write, 0);
    chk("rst.mem_addr", int'(mem_addr), 0);
    chk("rst.mem_wdata", int'(mem_wdata), 0);
    reset = 1;
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      run(tbl[k], $sformatf("vec%0d", k));
      if (k == 0) chk("vec0.m26", int'(wd(8'h26)), 16'hDEAD);
    end

    kick(1'b0, 8'h00, 8'h60, 7'd10, 16'h0);
    n = 0;
    for (int i = 0; i < 100 && n < 3; i++) begin @(negedge clk); if (mem_read) n++; end
    @(posedge clk); #1 abort = 1;
    @(posedge clk); #1 abort = 0;
    wait_ev();
    chk("abort_cap.words", int'(words_done), 2);
    chk("abort_cap.rd", rd_cnt, 3);
    chk("abort_cap.wr", wr_cnt, 2);
    chk("abort_cap.done", done_cnt, 1);

    kick(1'b0, 8'h00, 8'h60, 7'd10, 16'h0);
    n = 0;
    for (int i = 0; i < 100 && n < 3; i++) begin @(negedge clk); if (mem_write) n++; end
    abort = 1;
    @(posedge clk); #1 abort = 0;
    wait_ev();
    chk("abort_wr.words", int'(words_done), 3);
    chk("abort_wr.rd", rd_cnt, 3);
    chk("abort_wr.wr", wr_cnt, 3);
    chk("abort_wr.done", done_cnt, 1);

    kick(1'b0, 8'h00, 8'hA0, 7'd5, 16'h0);
    n = 0;
    for (int i = 0; i < 100 && n < 1; i++) begin @(negedge clk); if (mem_write) n++; end
    chk("arst.pre_wr", mem_write, 1);
    #1 reset = 0;
    #1;
    chk("arst.mem_write", mem_write, 0);
    chk("arst.busy", busy, 0);
    chk("arst.mem_read", mem_read, 0);
    chk("arst.words", int'(words_done), 0);
    @(negedge clk) reset = 1;
    run('{1'b1, 8'h00, 8'h10, 7'd2, 16'h5A5A, 0, 1, 2, 3, 2, 0, 2}, "post_rst");
    chk("strobe_overlap", both, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
